// File: rtl/wb_timer.sv
// wb_timer: Wishbone down-counting timer with prescaler, auto-reload/one-shot and level IRQ.
// Define WB_TIMER_CAPTURE_EN to add the synchronized capture input and CAPTURE register.
module wb_timer #(
  parameter int PRESC_WD = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        capture_i,
  output logic        irq_o
);

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic                ack_r;
  logic [31:0]         dat_r;
  logic                en_r, auto_r, irq_en_r;
  logic [PRESC_WD-1:0] presc_r, presc_cnt_r;
  logic [31:0]         load_r, count_r;
  logic                pend_r;

  logic        accept_s, wr_s, tick_s, expire_s;
  logic        wr_ctrl_s, wr_load_s, wr_count_s, wr_status_s;
  logic [31:0] ctrl_rd_s, status_rd_s, ctrl_wr_s, rd_data_s;
  logic [31:0] capture_val_s;
  logic        cap_pend_s;
  logic        unused_bits_s;

  assign accept_s = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s     = accept_s & wb_we_i;
  assign tick_s   = en_r & (presc_cnt_r == presc_r);
  assign expire_s = tick_s & (count_r == 32'd0);
  assign unused_bits_s = ^{ctrl_wr_s[15:3], wb_adr_i[31:5], wb_adr_i[1:0]};

  // Register read mux and write strobe decode.
  always_comb begin
    ctrl_rd_s = 32'd0;
    ctrl_rd_s[16 +: PRESC_WD] = presc_r;
    ctrl_rd_s[2:0] = {irq_en_r, auto_r, en_r};
    status_rd_s = {30'd0, cap_pend_s, pend_r};
    ctrl_wr_s = lane_merge(ctrl_rd_s, wb_dat_i, wb_sel_i);
    rd_data_s   = 32'd0;
    wr_ctrl_s   = 1'b0;
    wr_load_s   = 1'b0;
    wr_count_s  = 1'b0;
    wr_status_s = 1'b0;
    case (wb_adr_i[4:2])
      3'd0: begin rd_data_s = ctrl_rd_s;     wr_ctrl_s   = wr_s; end
      3'd1: begin rd_data_s = load_r;        wr_load_s   = wr_s; end
      3'd2: begin rd_data_s = count_r;       wr_count_s  = wr_s; end
      3'd3: begin rd_data_s = status_rd_s;   wr_status_s = wr_s; end
      3'd4: begin rd_data_s = capture_val_s;                     end
      default: begin rd_data_s = 32'd0;                          end
    endcase
  end

  // Bus handshake, register file, prescaler and counter; bus writes win over hardware updates.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r       <= 1'b0;
      dat_r       <= 32'd0;
      en_r        <= 1'b0;
      auto_r      <= 1'b0;
      irq_en_r    <= 1'b0;
      presc_r     <= {PRESC_WD{1'b0}};
      presc_cnt_r <= {PRESC_WD{1'b0}};
      load_r      <= 32'd0;
      count_r     <= 32'd0;
      pend_r      <= 1'b0;
    end else begin
      ack_r <= accept_s;
      dat_r <= (accept_s && !wb_we_i) ? rd_data_s : 32'd0;

      if (!en_r || tick_s) presc_cnt_r <= {PRESC_WD{1'b0}};
      else                 presc_cnt_r <= presc_cnt_r + PRESC_WD'(1'b1);

      if (wr_ctrl_s) begin
        en_r     <= ctrl_wr_s[0];
        auto_r   <= ctrl_wr_s[1];
        irq_en_r <= ctrl_wr_s[2];
        presc_r  <= ctrl_wr_s[16 +: PRESC_WD];
      end else if (expire_s && !auto_r) begin
        en_r <= 1'b0;
      end

      if (wr_load_s) load_r <= lane_merge(load_r, wb_dat_i, wb_sel_i);

      if (wr_count_s) begin
        count_r <= lane_merge(count_r, wb_dat_i, wb_sel_i);
      end else if (tick_s) begin
        if (count_r != 32'd0) count_r <= count_r - 32'd1;
        else if (auto_r)      count_r <= load_r;
      end

      // Expiry wins over a simultaneous W1C.
      if (expire_s)                                       pend_r <= 1'b1;
      else if (wr_status_s && wb_sel_i[0] && wb_dat_i[0]) pend_r <= 1'b0;
    end
  end

`ifdef WB_TIMER_CAPTURE_EN
  logic        sync1_r, sync2_r, sync3_r, cap_edge_r;
  logic [31:0] capture_r;
  logic        cap_pend_r;

  // Capture input synchronizer, registered rising-edge detect and CAPTURE/STATUS[1] update.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      sync3_r    <= 1'b0;
      cap_edge_r <= 1'b0;
      capture_r  <= 32'd0;
      cap_pend_r <= 1'b0;
    end else begin
      sync1_r    <= capture_i;
      sync2_r    <= sync1_r;
      sync3_r    <= sync2_r;
      cap_edge_r <= sync2_r & ~sync3_r;
      if (cap_edge_r) capture_r <= count_r;
      if (cap_edge_r)                                     cap_pend_r <= 1'b1;
      else if (wr_status_s && wb_sel_i[0] && wb_dat_i[1]) cap_pend_r <= 1'b0;
    end
  end

  assign capture_val_s = capture_r;
  assign cap_pend_s    = cap_pend_r;
`else
  logic unused_capture_s;
  assign unused_capture_s = capture_i;
  assign capture_val_s    = 32'd0;
  assign cap_pend_s       = 1'b0;
`endif

  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;
  assign irq_o    = pend_r & irq_en_r;

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer; expected values are hand-computed cycle by cycle.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack;
  logic        cap;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cap, exp_cstat;

  wb_timer #(.PRESC_WD(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (wdat),
    .wb_dat_o (rdat),
    .wb_ack_o (ack),
    .capture_i(cap),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called 1ns after a rising edge with ack low; accepted on the next edge, returns 1ns after the edge following it.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    check("ack_pulse_high", {31'd0, ack}, 32'd1);
    rd = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse_low", {31'd0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus(1'b1, a, d, s, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expv);
    logic [31:0] v;
    bus(1'b0, a, 32'd0, 4'hF, v);
    check(tag, v, expv);
  endtask

  task automatic irq_chk(input string tag, input logic expv);
    check(tag, {31'd0, irq}, {31'd0, expv});
  endtask

  initial begin
`ifdef WB_TIMER_CAPTURE_EN
    exp_cap = 32'd97;  exp_cstat = 32'd2;
`else
    exp_cap = 32'd0;   exp_cstat = 32'd0;
`endif
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 32'd0; wdat = 32'd0; sel = 4'h0; cap = 1'b0;
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    irq_chk("rst_irq", 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values of every offset
    rd_chk("rst_ctrl",    32'h00, 32'd0);
    rd_chk("rst_load",    32'h04, 32'd0);
    rd_chk("rst_count",   32'h08, 32'd0);
    rd_chk("rst_status",  32'h0C, 32'd0);
    rd_chk("rst_capture", 32'h10, 32'd0);
    rd_chk("rst_hole",    32'h14, 32'd0);

    // Auto-reload, PRESC=0: CTRL accepted at edge A, expiry at A+4 and every 4 after
    wr(32'h04, 32'd3, 4'hF);
    wr(32'h08, 32'd3, 4'hF);
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
    wr(32'h00, 32'h0000_0007, 4'hF);        // now A+1
    irq_chk("ar_irq_a1", 1'b0);
    repeat (2) @(posedge clk); #1;           // A+3
    irq_chk("ar_irq_a3", 1'b0);
    @(posedge clk); #1;                      // A+4
    irq_chk("ar_irq_a4", 1'b1);
    wr(32'h0C, 32'd1, 4'hF);                 // W1C at A+5, now A+6
    irq_chk("ar_irq_cleared", 1'b0);
    @(posedge clk); #1;                      // A+7
    irq_chk("ar_irq_a7", 1'b0);
    @(posedge clk); #1;                      // A+8
    irq_chk("ar_irq_a8", 1'b1);
    rd_chk("ar_count_reloaded", 32'h08, 32'd3);
    wr(32'h00, 32'd0, 4'hF);
    wr(32'h0C, 32'd1, 4'hF);
    rd_chk("ar_status_clear", 32'h0C, 32'd0);
    irq_chk("ar_irq_off", 1'b0);

    // One-shot, PRESC=2: CTRL accepted at C, expiry at C+9
    wr(32'h08, 32'd2, 4'hF);
    wr(32'h00, 32'h0002_0001, 4'hF);        // now C+1
    repeat (6) @(posedge clk); #1;           // C+7
    rd_chk("os_status_early", 32'h0C, 32'd0);   // accepted C+8
    rd_chk("os_ctrl_en_off", 32'h00, 32'h0002_0000); // accepted C+10
    rd_chk("os_status_pend", 32'h0C, 32'd1);
    rd_chk("os_count_zero",  32'h08, 32'd0);
    irq_chk("os_irq_masked", 1'b0);

    // W1C in the expiry cycle: CTRL accepted at D, expiry and W1C both at D+2
    wr(32'h0C, 32'd1, 4'hF);
    wr(32'h08, 32'd1, 4'hF);
    wr(32'h00, 32'h0000_0005, 4'hF);        // now D+1
    wr(32'h0C, 32'd1, 4'hF);                 // accepted D+2
    irq_chk("w1c_race_irq", 1'b1);
    rd_chk("w1c_race_pend", 32'h0C, 32'd1);
    irq_chk("w1c_before_clear", 1'b1);
    wr(32'h0C, 32'd1, 4'hF);
    irq_chk("w1c_irq_fall", 1'b0);
    rd_chk("w1c_ctrl", 32'h00, 32'h0000_0004);

    // Byte-lane write
    wr(32'h08, 32'h1234_5678, 4'hF);
    wr(32'h08, 32'hFFFF_FFFF, 4'b0010);
    rd_chk("sel_lane1", 32'h08, 32'h1234_FF78);

    // Capture: CTRL accepted at Y, COUNT = 100 after Y+100
    wr(32'h00, 32'd0, 4'hF);
    wr(32'h08, 32'd200, 4'hF);
    wr(32'h00, 32'h0000_0001, 4'hF);        // now Y+1
    repeat (99) @(posedge clk); #1;          // Y+100
    cap = 1'b1;
    repeat (3) @(posedge clk); #1;
    cap = 1'b0;
    wr(32'h00, 32'd0, 4'hF);
    rd_chk("cap_value",  32'h10, exp_cap);
    rd_chk("cap_status", 32'h0C, exp_cstat);
    wr(32'h0C, 32'd2, 4'hF);
    rd_chk("cap_status_w1c", 32'h0C, 32'd0);

    // Reset in the middle of a transfer
    wr(32'h08, 32'h0000_00AA, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h08; sel = 4'hF;
    @(posedge clk); #1;
    check("mid_ack_high", {31'd0, ack}, 32'd1);
    check("mid_dat", rdat, 32'h0000_00AA);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("post_rst_count", 32'h08, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter PRESC_WD, default 16, sets the prescaler register width (1..16).
REQ-002 Port wb_clk_i, input, 1, system clock; all logic is on its rising edge.
REQ-003 Port wb_rst_i, input, 1, asynchronous active-high reset.
REQ-004 Port wb_cyc_i, input, 1, Wishbone cycle.
REQ-005 Port wb_stb_i, input, 1, Wishbone strobe.
REQ-006 Port wb_we_i, input, 1, write enable.
REQ-007 Port wb_adr_i, input, 32, byte address; only [4:2] decoded.
REQ-008 Port wb_sel_i, input, 4, byte lane enables for writes.
REQ-009 Port wb_dat_i, input, 32, write data.
REQ-010 Port wb_dat_o, output, 32, read data.
REQ-011 Port wb_ack_o, output, 1, transfer acknowledge.
REQ-012 Port capture_i, input, 1, asynchronous capture strobe.
REQ-013 Port irq_o, output, 1, level interrupt to the user-project irq bus.

Function
REQ-014 Register map: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT, 0x0C STATUS, 0x10 CAPTURE; offsets 0x14-0x1C read 0 and ignore writes.
REQ-015 CTRL fields: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [15:3] reserved (read 0), [16+PRESC_WD-1:16] PRESC.
REQ-016 Requests are accepted when wb_cyc_i & wb_stb_i & !wb_ack_o.
REQ-017 wb_ack_o asserts exactly one cycle after acceptance and stays high for one cycle only, so back-to-back strobes complete every second cycle.
REQ-018 Writes take effect on the acceptance edge and update only the byte lanes whose wb_sel_i bit is 1.
REQ-019 wb_dat_o is registered, is valid while wb_ack_o is high, and is 0 otherwise.
REQ-020 While EN=1, the prescaler counts 0..PRESC and emits one tick when it wraps; PRESC=0 yields a tick every cycle.
REQ-021 Clearing EN resets the prescaler to 0 and freezes COUNT.
REQ-022 On a tick with COUNT!=0, COUNT decrements by 1.
REQ-023 On a tick with COUNT==0, STATUS[0] (PEND) sets. If AUTO_RELOAD=1, COUNT<=LOAD. Otherwise EN clears and COUNT stays 0 (one-shot).
REQ-024 A write to COUNT in the same cycle as a tick takes priority over the decrement and reload.
REQ-025 A write to CTRL in the same cycle as a one-shot expiry takes priority over the hardware clear of EN.
REQ-026 Writing 1 to STATUS[0] clears PEND; if expiry occurs in the same cycle, PEND stays set (set wins).
REQ-027 irq_o = PEND & IRQ_EN, driven combinationally from registers.

Reset
REQ-028 While wb_rst_i is high, all registers, the prescaler, the synchronizer and PEND are 0; wb_ack_o=0, wb_dat_o=0, irq_o=0.
REQ-029 A reset asserted mid-transfer drops wb_ack_o immediately; the master re-issues the access.
REQ-030 Reset release is synchronous to wb_clk_i in the surrounding system; the block requires no extra gating.

Configuration
REQ-031 With WB_TIMER_CAPTURE_EN defined, capture_i passes through a 2-flop synchronizer and a rising-edge detector. Each detected edge loads COUNT into CAPTURE 3 cycles after the input edge and sets STATUS[1], which is cleared by writing 1.
REQ-032 Without WB_TIMER_CAPTURE_EN, capture_i is ignored, CAPTURE and STATUS[1] read 0, and no synchronizer flops exist.

Verification
REQ-033 Reset, then read all five offsets -> every read returns 0x00000000, and every wb_ack_o is a single-cycle pulse one cycle after the strobe.
REQ-034 Write LOAD=3 and COUNT=3, then CTRL=0x7 (PRESC=0) -> PEND and irq_o set on the 4th tick after EN; COUNT reloads to 3 and repeats every 4 cycles.
REQ-035 Write COUNT=2, then CTRL=0x0002_0001 (PRESC=2, one-shot) -> expiry after 9 cycles; EN reads 0 and COUNT holds 0; irq_o stays 0 because IRQ_EN=0.
REQ-036 Write STATUS=1 in the same cycle as an expiry -> PEND remains 1; a W1C in a later cycle clears it and irq_o falls the next cycle.
REQ-037 Write COUNT=0xFFFF_FFFF with wb_sel_i=0b0010 -> COUNT[15:8]=0xFF and all other bytes are unchanged.
REQ-038 With WB_TIMER_CAPTURE_EN defined, pulse capture_i while COUNT=100 and decrementing every cycle -> CAPTURE=97 and STATUS[1]=1. Without the macro, the same stimulus gives CAPTURE=0.
